interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
Upstream companion of the multi-cycle control unit. Collects external maskable IRQ lines and one NMI line, then synchronises, edge-detects, latches and prioritises them. Drives the control unit's INT_control / NMI_control request inputs with a registered request/acknowledge/end-of-interrupt handshake. Supports one level of NMI-over-INT preemption.

Parameters:
NUM_IRQ, 8, number of maskable IRQ lines (2..16)
ID_W, 3, width of irq_id; must satisfy 2**ID_W >= NUM_IRQ

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
irq_in  in  NUM_IRQ  asynchronous maskable interrupt lines, rising-edge triggered
nmi_in  in  1  asynchronous non-maskable interrupt line, rising-edge triggered
int_enable  in  1  global maskable-interrupt enable
mask_we  in  1  write strobe for the mask register
mask_wdata  in  NUM_IRQ  new mask value; 1 = line enabled
ack  in  1  one-cycle pulse from the control unit when it enters an interrupt state
eoi  in  1  one-cycle end-of-interrupt pulse from the handler return path
INT_control  out  1  maskable interrupt request to the control unit
NMI_control  out  1  NMI request to the control unit
irq_id  out  ID_W  index of the IRQ being requested or serviced
pending  out  NUM_IRQ  latched pending bits
mask  out  NUM_IRQ  current mask register
in_service  out  1  high in INT_SVC or NMI_SVC

Behaviour:
- Reset values: INT_control=0, NMI_control=0, irq_id=0, pending=0, mask=0 (all lines disabled), in_service=0, synchroniser flops=0, FSM=IDLE, preempted=0.
- Reset mid-operation discards all pending requests, outstanding requests and preemption state.
- Input path: irq_in and nmi_in each pass through a 2-flop synchroniser followed by a previous-value flop. An edge is sync2 & ~prev.
- Latency: a line first sampled high at edge k sets its pending bit at edge k+2. The matching request output is high after edge k+3.
- pending[i] sets on an edge of line i and clears on ack while irq_id==i in INT_REQ. If a new edge and the clearing ack hit the same bit in the same cycle, the bit stays set.
- The mask gates requests only. A masked edge still sets pending. mask_we updates mask on the next edge.
- Priority: lowest index wins among pending & mask.
- nmi_pend sets on an NMI edge and clears on ack in NMI_REQ. NMI always beats INT.
- FSM states: IDLE, INT_REQ, INT_SVC, NMI_REQ, NMI_SVC.
  - IDLE -> NMI_REQ if nmi_pend.
  - IDLE -> INT_REQ if int_enable and (pending & mask) is nonzero; irq_id is loaded with the winner.
  - INT_REQ: INT_control=1 and irq_id is held stable.
    - ack -> INT_SVC.
    - nmi_pend, int_enable=0, or the winner becoming masked -> drop the request and return to IDLE (or go to NMI_REQ); pending is kept.
  - INT_SVC: INT_control=0. No new INT request until eoi.
    - eoi -> IDLE.
    - nmi_pend -> NMI_REQ with preempted=1.
  - NMI_REQ: NMI_control=1.
    - ack -> NMI_SVC.
  - NMI_SVC: all requests are blocked.
    - eoi -> INT_SVC if preempted (preempted clears, irq_id is restored), else IDLE.
    - An NMI edge during NMI_SVC stays latched in nmi_pend and is served after eoi.
- ack or eoi arriving in a state that does not consume it is ignored. ack in IDLE has no effect.
- Request outputs are registered and are never both high.

Optional Feature:
INTC_LEVEL_TRIG_EN
- Defined: irq lines are level-sensitive. pending mirrors the synchronised irq_in (sync2) directly, with no latching, and ack does not clear it. The device clears its line before eoi. NMI stays edge-triggered.
- Not defined: edge-triggered latching as described above.

Test Plan:
- rst, mask=8'hFF, int_enable=1, irq_in[3] rising at edge 10 -> pending[3]=1 after edge 12, INT_control=1 with irq_id=3 after edge 13, held until ack.
- irq_in[5] and irq_in[2] rise in the same cycle -> irq_id=2 first. After ack and eoi, a second request is raised with irq_id=5.
- In INT_SVC with irq_id=4, an nmi_in rise -> NMI_control=1. ack -> NMI_SVC. eoi -> back to INT_SVC with irq_id=4, in_service=1. A second eoi -> IDLE.
- mask=8'h00, irq_in[1] rises -> pending[1]=1, INT_control stays 0. Writing mask=8'h02 -> INT_control=1 on the next request cycle.
- INT_REQ with int_enable dropping to 0 -> INT_control=0 the next cycle and pending is kept. Re-enabling re-raises the request. Asserting rst mid-request -> all outputs return to their reset values the next cycle.
- ack and a new irq_in[0] edge hit pending[0] in the same cycle -> pending[0] stays 1 and a fresh request follows eoi.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Bundle between the interrupt sources / control unit and interrupt_controller.
// master drives the IRQ lines and handshake pulses; slave is the controller.
interface interrupt_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               nmi_in;
    logic               int_enable;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               ack;
    logic               eoi;
    logic               INT_control;
    logic               NMI_control;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic               in_service;

    modport master (
        output irq_in, nmi_in, int_enable, mask_we, mask_wdata, ack, eoi,
        input  INT_control, NMI_control, irq_id, pending, mask, in_service
    );

    modport slave (
        input  irq_in, nmi_in, int_enable, mask_we, mask_wdata, ack, eoi,
        output INT_control, NMI_control, irq_id, pending, mask, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// IRQ/NMI synchroniser, pending latch, priority pick and request handshake FSM.
// Define INTC_LEVEL_TRIG_EN for level-sensitive IRQ lines (NMI stays edge-triggered).
module interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    interrupt_controller_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INT_REQ, INT_SVC, NMI_REQ, NMI_SVC} state_t;

    state_t             r_state, w_state_n;
    logic [NUM_IRQ-1:0] r_irq_s1, r_irq_s2, r_mask;
    logic               r_nmi_s1, r_nmi_s2, r_nmi_prev, r_nmi_pend;
    logic [ID_W-1:0]    r_irq_id, w_win_id;
    logic               r_preempted, r_int_ctrl, r_nmi_ctrl, r_in_svc;
    logic [NUM_IRQ-1:0] w_pend, w_req;
    logic               w_any, w_cur_ok, w_ack_int, w_ack_nmi, w_nmi_edge;
    logic               w_load_id, w_set_pre, w_clr_pre;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_s1   <= '0;
            r_irq_s2   <= '0;
            r_nmi_s1   <= 1'b0;
            r_nmi_s2   <= 1'b0;
            r_nmi_prev <= 1'b0;
        end else begin
            r_irq_s1   <= bus.irq_in;
            r_irq_s2   <= r_irq_s1;
            r_nmi_s1   <= bus.nmi_in;
            r_nmi_s2   <= r_nmi_s1;
            r_nmi_prev <= r_nmi_s2;
        end
    end

    assign w_nmi_edge = r_nmi_s2 & ~r_nmi_prev;
    assign w_ack_int  = (r_state == INT_REQ) & bus.ack;
    assign w_ack_nmi  = (r_state == NMI_REQ) & bus.ack;

`ifdef INTC_LEVEL_TRIG_EN
    assign w_pend = r_irq_s2;
`else
    logic [NUM_IRQ-1:0] r_irq_prev, r_pend, w_clr;

    assign w_clr = w_ack_int ? (NUM_IRQ'(1) << r_irq_id) : '0;

    // A fresh edge wins over the ack clearing the same bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_prev <= '0;
            r_pend     <= '0;
        end else begin
            r_irq_prev <= r_irq_s2;
            r_pend     <= (r_pend & ~w_clr) | (r_irq_s2 & ~r_irq_prev);
        end
    end

    assign w_pend = r_pend;
`endif

    assign w_req    = w_pend & r_mask;
    assign w_any    = |w_req;
    assign w_cur_ok = |(w_req & (NUM_IRQ'(1) << r_irq_id));

    always_comb begin
        w_win_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) w_win_id = ID_W'(i);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_load_id = 1'b0;
        w_set_pre = 1'b0;
        w_clr_pre = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_nmi_pend) begin
                    w_state_n = NMI_REQ;
                end else if (bus.int_enable && w_any) begin
                    w_state_n = INT_REQ;
                    w_load_id = 1'b1;
                end
            end
            INT_REQ: begin
                if (bus.ack)                              w_state_n = INT_SVC;
                else if (r_nmi_pend)                      w_state_n = NMI_REQ;
                else if (!bus.int_enable || !w_cur_ok)    w_state_n = IDLE;
            end
            // eoi first: a finished handler needs no preemption bookkeeping.
            INT_SVC: begin
                if (bus.eoi) begin
                    w_state_n = IDLE;
                end else if (r_nmi_pend) begin
                    w_state_n = NMI_REQ;
                    w_set_pre = 1'b1;
                end
            end
            NMI_REQ: begin
                if (bus.ack) w_state_n = NMI_SVC;
            end
            NMI_SVC: begin
                if (bus.eoi) begin
                    w_state_n = r_preempted ? INT_SVC : IDLE;
                    w_clr_pre = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_irq_id    <= '0;
            r_mask      <= '0;
            r_preempted <= 1'b0;
            r_nmi_pend  <= 1'b0;
            r_int_ctrl  <= 1'b0;
            r_nmi_ctrl  <= 1'b0;
            r_in_svc    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_load_id) r_irq_id <= w_win_id;
            if (bus.mask_we) r_mask <= bus.mask_wdata;
            if (w_set_pre)      r_preempted <= 1'b1;
            else if (w_clr_pre) r_preempted <= 1'b0;
            r_nmi_pend <= (r_nmi_pend & ~w_ack_nmi) | w_nmi_edge;
            r_int_ctrl <= (w_state_n == INT_REQ);
            r_nmi_ctrl <= (w_state_n == NMI_REQ);
            r_in_svc   <= (w_state_n == INT_SVC) || (w_state_n == NMI_SVC);
        end
    end

    assign bus.INT_control = r_int_ctrl;
    assign bus.NMI_control = r_nmi_ctrl;
    assign bus.irq_id      = r_irq_id;
    assign bus.pending     = w_pend;
    assign bus.mask        = r_mask;
    assign bus.in_service  = r_in_svc;
endmodule
